// File: rtl/mem_arbiter_nport.sv
// N-requestor arbiter onto a dual-port memory: one request FIFO per requestor,
// up to two head entries issued per cycle (port A, then port B), responses one cycle later.
module mem_arbiter_nport #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BUF_DEPTH  = 2,
  parameter int ARB_MODE   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] resp_rdata,
  output logic                          mem_a_en,
  output logic                          mem_a_we,
  output logic [ADDR_WIDTH-1:0]         mem_a_addr,
  output logic [DATA_WIDTH-1:0]         mem_a_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_a_q,
  output logic                          mem_b_en,
  output logic                          mem_b_we,
  output logic [ADDR_WIDTH-1:0]         mem_b_addr,
  output logic [DATA_WIDTH-1:0]         mem_b_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_b_q
);

  localparam int PW = $clog2(BUF_DEPTH) + 1;
  localparam int IW = $clog2(NUM_REQ);
  localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;

  // Entry layout: {we, addr, wdata}
  logic [EW-1:0]      buf_q    [NUM_REQ][BUF_DEPTH];
  logic [EW-1:0]      buf_d    [NUM_REQ][BUF_DEPTH];
  logic [PW-1:0]      wr_ptr_q [NUM_REQ];
  logic [PW-1:0]      wr_ptr_d [NUM_REQ];
  logic [PW-1:0]      rd_ptr_q [NUM_REQ];
  logic [PW-1:0]      rd_ptr_d [NUM_REQ];
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;

  logic               tag_a_vld_q, tag_a_vld_d;
  logic               tag_a_we_q,  tag_a_we_d;
  logic [IW-1:0]      tag_a_idx_q, tag_a_idx_d;
  logic               tag_b_vld_q, tag_b_vld_d;
  logic               tag_b_we_q,  tag_b_we_d;
  logic [IW-1:0]      tag_b_idx_q, tag_b_idx_d;

  logic [NUM_REQ-1:0] full, empty, push, pop;
  logic [EW-1:0]      head [NUM_REQ];
  logic [EW-1:0]      head_a, head_b;
  logic               grant_a, grant_b, found_b;
  logic [IW-1:0]      cand_a, cand_b, scan_idx;
  int unsigned        rr_start;

  always_comb begin
    empty = '0;
    full  = '0;
    head  = '{default: '0};
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][PW-1] != rd_ptr_q[i][PW-1]) &&
                 (wr_ptr_q[i][PW-2:0] == rd_ptr_q[i][PW-2:0]);
      head[i]  = buf_q[i][rd_ptr_q[i][PW-2:0]];
    end
  end

  assign req_ready = ~full;
  assign push      = req_valid & ~full;
  assign rr_start  = (ARB_MODE == 1) ? 32'(rr_ptr_q) : 32'd0;

  // Scan heads in rank order; first hit goes to port A, second to port B.
  always_comb begin
    grant_a  = 1'b0;
    found_b  = 1'b0;
    cand_a   = '0;
    cand_b   = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = IW'((rr_start + k) % NUM_REQ);
      if (!empty[scan_idx]) begin
        if (!grant_a) begin
          grant_a = 1'b1;
          cand_a  = scan_idx;
        end else if (!found_b) begin
          found_b = 1'b1;
          cand_b  = scan_idx;
        end
      end
    end
    head_a = head[cand_a];
    head_b = head[cand_b];
    // Same address with any write: B would race A, so B waits a cycle.
    grant_b = found_b &&
              !((head_a[EW-2 -: ADDR_WIDTH] == head_b[EW-2 -: ADDR_WIDTH]) &&
                (head_a[EW-1] || head_b[EW-1]));
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pop[i] = (grant_a && (cand_a == IW'(i))) || (grant_b && (cand_b == IW'(i)));
    end
  end

  always_comb begin
    mem_a_en    = grant_a;
    mem_a_we    = 1'b0;
    mem_a_addr  = '0;
    mem_a_wdata = '0;
    mem_b_en    = grant_b;
    mem_b_we    = 1'b0;
    mem_b_addr  = '0;
    mem_b_wdata = '0;
    if (grant_a) begin
      mem_a_we    = head_a[EW-1];
      mem_a_addr  = head_a[EW-2 -: ADDR_WIDTH];
      mem_a_wdata = head_a[DATA_WIDTH-1:0];
    end
    if (grant_b) begin
      mem_b_we    = head_b[EW-1];
      mem_b_addr  = head_b[EW-2 -: ADDR_WIDTH];
      mem_b_wdata = head_b[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (push[i]) begin
        buf_d[i][wr_ptr_q[i][PW-2:0]] = {req_we[i],
                                         req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                                         req_wdata[i*DATA_WIDTH +: DATA_WIDTH]};
        wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_b) begin
      rr_ptr_d = IW'((32'(cand_b) + 32'd1) % NUM_REQ);
    end else if (grant_a) begin
      rr_ptr_d = IW'((32'(cand_a) + 32'd1) % NUM_REQ);
    end
    tag_a_vld_d = grant_a;
    tag_a_idx_d = cand_a;
    tag_a_we_d  = head_a[EW-1];
    tag_b_vld_d = grant_b;
    tag_b_idx_d = cand_b;
    tag_b_we_d  = head_b[EW-1];
  end

  always_comb begin
    resp_valid = '0;
    resp_rdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (tag_a_vld_q && (tag_a_idx_q == IW'(i))) begin
        resp_valid[i] = 1'b1;
        if (!tag_a_we_q) resp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem_a_q;
      end
      if (tag_b_vld_q && (tag_b_idx_q == IW'(i))) begin
        resp_valid[i] = 1'b1;
        if (!tag_b_we_q) resp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem_b_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '{default: '0};
      wr_ptr_q    <= '{default: '0};
      rd_ptr_q    <= '{default: '0};
      rr_ptr_q    <= '0;
      tag_a_vld_q <= 1'b0;
      tag_a_we_q  <= 1'b0;
      tag_a_idx_q <= '0;
      tag_b_vld_q <= 1'b0;
      tag_b_we_q  <= 1'b0;
      tag_b_idx_q <= '0;
    end else begin
      buf_q       <= buf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rr_ptr_q    <= rr_ptr_d;
      tag_a_vld_q <= tag_a_vld_d;
      tag_a_we_q  <= tag_a_we_d;
      tag_a_idx_q <= tag_a_idx_d;
      tag_b_vld_q <= tag_b_vld_d;
      tag_b_we_q  <= tag_b_we_d;
      tag_b_idx_q <= tag_b_idx_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_nport.sv
// Bench for mem_arbiter_nport: fixed-priority and round-robin instances share stimulus,
// each checked every cycle against a queue-based reference model, plus directed scenarios.
module tb_mem_arbiter_nport;
  localparam int N     = 3;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;

  logic [N-1:0]    ready_o [2];
  logic [N-1:0]    rv_o    [2];
  logic [N*DW-1:0] rd_o    [2];
  logic            a_en [2], a_we [2], b_en [2], b_we [2];
  logic [AW-1:0]   a_addr [2], b_addr [2];
  logic [DW-1:0]   a_wd [2], b_wd [2], a_q [2], b_q [2];

  mem_arbiter_nport #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                      .BUF_DEPTH(DEPTH), .ARB_MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_o[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_o[0]), .resp_rdata(rd_o[0]),
    .mem_a_en(a_en[0]), .mem_a_we(a_we[0]), .mem_a_addr(a_addr[0]),
    .mem_a_wdata(a_wd[0]), .mem_a_q(a_q[0]),
    .mem_b_en(b_en[0]), .mem_b_we(b_we[0]), .mem_b_addr(b_addr[0]),
    .mem_b_wdata(b_wd[0]), .mem_b_q(b_q[0]));

  mem_arbiter_nport #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                      .BUF_DEPTH(DEPTH), .ARB_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_o[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_o[1]), .resp_rdata(rd_o[1]),
    .mem_a_en(a_en[1]), .mem_a_we(a_we[1]), .mem_a_addr(a_addr[1]),
    .mem_a_wdata(a_wd[1]), .mem_a_q(a_q[1]),
    .mem_b_en(b_en[1]), .mem_b_we(b_we[1]), .mem_b_addr(b_addr[1]),
    .mem_b_wdata(b_wd[1]), .mem_b_q(b_q[1]));

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {8'hA5, a, 8'h5A, ~a};
  endfunction

  // Behavioural dual-port memory, one per instance; read data one cycle after the strobe.
  logic [31:0] dev_mem [2][256];
  logic        dev_init = 1'b1;
  always @(posedge clk) begin
    if (dev_init) begin
      for (int d = 0; d < 2; d++)
        for (int a = 0; a < 256; a++) dev_mem[d][a] <= init_val(8'(a));
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (a_en[d]) begin
          if (a_we[d]) dev_mem[d][a_addr[d][7:0]] <= a_wd[d];
          else         a_q[d] <= dev_mem[d][a_addr[d][7:0]];
        end
        if (b_en[d]) begin
          if (b_we[d]) dev_mem[d][b_addr[d][7:0]] <= b_wd[d];
          else         b_q[d] <= dev_mem[d][b_addr[d][7:0]];
        end
      end
    end
  end

  // Reference model: per-requestor queues, rank list, expected responses.
  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } ent_t;
  ent_t        mq [2][N][$];
  int          m_ptr [2];
  logic [N-1:0] m_rv [2];
  logic [31:0] m_rd [2][N];
  logic [31:0] mdl_mem [2][256];
  int          pa [2], pb [2];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < N; r++) begin
        mq[d][r].delete();
        m_rd[d][r] = '0;
      end
      m_ptr[d] = 0;
      m_rv[d]  = '0;
    end
  endtask

  task automatic predict(input int d);
    int   order [$];
    int   start;
    ent_t ea, eb;
    order = {};
    start = (d == 1) ? m_ptr[d] : 0;
    for (int k = 0; k < N; k++)
      if (mq[d][(start + k) % N].size() > 0) order.push_back((start + k) % N);
    pa[d] = -1;
    pb[d] = -1;
    if (order.size() > 0) pa[d] = order[0];
    if (order.size() > 1) begin
      ea = mq[d][order[0]][0];
      eb = mq[d][order[1]][0];
      if (!(ea.addr == eb.addr && (ea.we || eb.we))) pb[d] = order[1];
    end
  endtask

  task automatic model_check(input int d);
    logic [N-1:0]    rdy;
    logic [65:0]     ea, eb;
    logic [N*DW-1:0] rd;
    ent_t            e;
    for (int i = 0; i < N; i++) begin
      rdy[i] = (mq[d][i].size() < DEPTH);
      rd[i*DW +: DW] = m_rd[d][i];
    end
    ea = '0;
    eb = '0;
    if (pa[d] >= 0) begin e = mq[d][pa[d]][0]; ea = {1'b1, e.we, e.addr, e.wdata}; end
    if (pb[d] >= 0) begin e = mq[d][pb[d]][0]; eb = {1'b1, e.we, e.addr, e.wdata}; end
    chk($sformatf("ready[%0d]", d), 128'(ready_o[d]), 128'(rdy));
    chk($sformatf("mem_a[%0d]", d), 128'({a_en[d], a_we[d], a_addr[d], a_wd[d]}), 128'(ea));
    chk($sformatf("mem_b[%0d]", d), 128'({b_en[d], b_we[d], b_addr[d], b_wd[d]}), 128'(eb));
    chk($sformatf("resp_valid[%0d]", d), 128'(rv_o[d]), 128'(m_rv[d]));
    chk($sformatf("resp_rdata[%0d]", d), 128'(rd_o[d]), 128'(rd));
  endtask

  task automatic model_update(input int d);
    logic [N-1:0] rdy;
    ent_t         e;
    int           last;
    for (int i = 0; i < N; i++) begin
      rdy[i] = (mq[d][i].size() < DEPTH);
      m_rd[d][i] = '0;
    end
    m_rv[d] = '0;
    if (pa[d] >= 0) begin
      e = mq[d][pa[d]][0];
      m_rv[d][pa[d]] = 1'b1;
      if (!e.we) m_rd[d][pa[d]] = mdl_mem[d][e.addr[7:0]];
    end
    if (pb[d] >= 0) begin
      e = mq[d][pb[d]][0];
      m_rv[d][pb[d]] = 1'b1;
      if (!e.we) m_rd[d][pb[d]] = mdl_mem[d][e.addr[7:0]];
    end
    if (pa[d] >= 0) begin
      e = mq[d][pa[d]].pop_front();
      if (e.we) mdl_mem[d][e.addr[7:0]] = e.wdata;
    end
    if (pb[d] >= 0) begin
      e = mq[d][pb[d]].pop_front();
      if (e.we) mdl_mem[d][e.addr[7:0]] = e.wdata;
    end
    last = (pb[d] >= 0) ? pb[d] : pa[d];
    if (last >= 0) m_ptr[d] = (last + 1) % N;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && rdy[i]) begin
        e.we    = req_we[i];
        e.addr  = req_addr[i*AW +: AW];
        e.wdata = req_wdata[i*DW +: DW];
        mq[d][i].push_back(e);
      end
    end
  endtask

  task automatic tick();
    #1;
    for (int d = 0; d < 2; d++) begin
      predict(d);
      model_check(d);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_update(d);
    @(negedge clk);
  endtask

  task automatic idle_in();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_in(input int r, input logic v, input logic we,
                        input logic [31:0] addr, input logic [31:0] wd);
    req_valid[r]         = v;
    req_we[r]            = we;
    req_addr[r*AW +: AW] = addr;
    req_wdata[r*DW +: DW] = wd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_in();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_mem_en[%0d]", d), 128'({a_en[d], b_en[d]}), 128'(0));
      chk($sformatf("rst_mem_out[%0d]", d),
          128'({a_we[d], a_addr[d], a_wd[d], b_we[d], b_addr[d], b_wd[d]}), 128'(0));
      chk($sformatf("rst_resp[%0d]", d), 128'({rv_o[d], rd_o[d]}), 128'(0));
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_clear();
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("post_rst_ready[%0d]", d), 128'(ready_o[d]), 128'(3'b111));
  endtask

  task automatic grant_check(input int d, input int ea, input int eb);
    logic [32:0] xa, xb;
    xa = (ea < 0) ? 33'd0 : {1'b1, 32'h20 + 32'(ea)};
    xb = (eb < 0) ? 33'd0 : {1'b1, 32'h20 + 32'(eb)};
    chk($sformatf("tbl_grant_a[%0d]", d), 128'({a_en[d], a_addr[d]}), 128'(xa));
    chk($sformatf("tbl_grant_b[%0d]", d), 128'({b_en[d], b_addr[d]}), 128'(xb));
  endtask

  typedef struct {
    logic         rst_first;
    logic [N-1:0] valid;
    int           fa, fb, ra, rb;
  } vec_t;
  vec_t tbl [11];

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [31:0] got [$];
    int          cnt2;
    logic        acc;

    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 256; a++) mdl_mem[d][a] = init_val(8'(a));
    model_clear();
    idle_in();
    #1;
    do_reset();
    dev_init = 1'b0;

    // Single read of 0x10: strobe in cycle 1, response with memory data in cycle 2.
    set_in(0, 1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    idle_in();
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("rd1_issue[%0d]", d), 128'({a_en[d], a_we[d], a_addr[d], b_en[d]}),
          128'({1'b1, 1'b0, 32'h10, 1'b0}));
    tick();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rd1_rv[%0d]", d), 128'(rv_o[d]), 128'(3'b001));
      chk($sformatf("rd1_data[%0d]", d), 128'(rd_o[d][31:0]), 128'(32'hDEADBEEF));
    end
    tick();

    // Grant tables: one-shot triple read, then continuous triple read.
    tbl[0]  = '{1'b1, 3'b111, -1, -1, -1, -1};
    tbl[1]  = '{1'b0, 3'b000,  0,  1,  0,  1};
    tbl[2]  = '{1'b0, 3'b000,  2, -1,  2, -1};
    tbl[3]  = '{1'b0, 3'b000, -1, -1, -1, -1};
    tbl[4]  = '{1'b1, 3'b111, -1, -1, -1, -1};
    tbl[5]  = '{1'b0, 3'b111,  0,  1,  0,  1};
    tbl[6]  = '{1'b0, 3'b111,  0,  1,  2,  0};
    tbl[7]  = '{1'b0, 3'b111,  0,  1,  1,  2};
    tbl[8]  = '{1'b0, 3'b111,  0,  1,  0,  1};
    tbl[9]  = '{1'b0, 3'b111,  0,  1,  2,  0};
    tbl[10] = '{1'b0, 3'b111,  0,  1,  1,  2};
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst_first) do_reset();
      idle_in();
      for (int r = 0; r < N; r++) set_in(r, tbl[i].valid[r], 1'b0, 32'h20 + 32'(r), 32'h0);
      #1;
      grant_check(0, tbl[i].fa, tbl[i].fb);
      grant_check(1, tbl[i].ra, tbl[i].rb);
      tick();
    end
    idle_in();
    repeat (8) tick();

    // Back-pressure: 0 and 1 saturate, requestor 2 offers five sequential reads.
    do_reset();
    cnt2 = 0;
    for (int c = 0; c < 5; c++) begin
      idle_in();
      set_in(0, 1'b1, 1'b0, 32'h20, 32'h0);
      set_in(1, 1'b1, 1'b0, 32'h21, 32'h0);
      set_in(2, 1'b1, 1'b0, 32'h30 + 32'(cnt2), 32'h0);
      #1;
      chk($sformatf("bp_ready2_c%0d", c), 128'(ready_o[0][2]), 128'(c < 2));
      acc = ready_o[0][2];
      tick();
      if (acc) cnt2++;
    end
    chk("bp_accepts", 128'(cnt2), 128'(2));
    idle_in();
    got = {};
    for (int c = 0; c < 12; c++) begin
      #1;
      if (rv_o[0][2]) got.push_back(rd_o[0][95:64]);
      tick();
    end
    chk("bp_resp_count", 128'(got.size()), 128'(2));
    if (got.size() == 2) begin
      chk("bp_resp0", 128'(got[0]), 128'(init_val(8'h30)));
      chk("bp_resp1", 128'(got[1]), 128'(init_val(8'h31)));
    end

    // Same-address write conflict, then read-back.
    do_reset();
    set_in(0, 1'b1, 1'b1, 32'h40, 32'h11111111);
    set_in(1, 1'b1, 1'b1, 32'h40, 32'h22222222);
    tick();
    idle_in();
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("cf_c1[%0d]", d), 128'({a_en[d], a_we[d], a_addr[d], a_wd[d], b_en[d]}),
          128'({1'b1, 1'b1, 32'h40, 32'h11111111, 1'b0}));
    tick();
    set_in(2, 1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("cf_c2[%0d]", d), 128'({a_en[d], a_we[d], a_addr[d], a_wd[d], b_en[d]}),
          128'({1'b1, 1'b1, 32'h40, 32'h22222222, 1'b0}));
    tick();
    idle_in();
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("cf_c3[%0d]", d), 128'({a_en[d], a_we[d], a_addr[d]}),
          128'({1'b1, 1'b0, 32'h40}));
    tick();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("cf_rv[%0d]", d), 128'(rv_o[d]), 128'(3'b100));
      chk($sformatf("cf_data[%0d]", d), 128'(rd_o[d][95:64]), 128'(32'h22222222));
    end
    tick();

    // Reset with entries queued and responses in flight.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      idle_in();
      for (int r = 0; r < N; r++) set_in(r, 1'b1, 1'b0, 32'h50 + 32'(c), 32'h0);
      tick();
    end
    do_reset();
    for (int c = 0; c < 5; c++) begin
      #1;
      for (int d = 0; d < 2; d++)
        chk($sformatf("rst_drop_rv[%0d]", d), 128'(rv_o[d]), 128'(0));
      tick();
    end

    // Randomised traffic against the model, with one mid-run reset.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset();
      idle_in();
      for (int r = 0; r < N; r++)
        set_in(r, ($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
               32'h80 + 32'($urandom_range(0, 5)), $urandom);
      tick();
    end
    idle_in();
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
